// File: rtl/draw_sched_pkg.sv
// Shared definitions for the draw scheduler: FSM state encoding and default
// pixel bus widths matching the vga_adapter.
package draw_sched_pkg;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_RUN  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

endpackage

// File: rtl/draw_pick.sv
// Combinational search for the lowest set mask bit at or above pointer p.
// The pointer is one bit wider than the index so it can reach N_CH,
// which means "past the last channel" and never matches.
module draw_pick #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  mask_i,
  input  logic [IDX_W:0]   p_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan downwards so the last match written is the lowest eligible index.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && ((IDX_W+1)'(i) >= p_i)) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-based arbiter that hands the single vga_adapter pixel port to one
// drawer channel at a time, in ascending index order, with a grant watchdog
// and optional frame-locked rounds.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int C_W        = DEF_C_W,
  parameter int TIMEOUT    = 4096,
  parameter int WAIT_FRAME = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_CH-1:0]           ch_en_i,
  input  logic                      frame_tick_i,
  output logic [N_CH-1:0]           go_o,
  input  logic [N_CH-1:0]           done_i,
  input  logic [N_CH*X_W-1:0]       ch_x_i,
  input  logic [N_CH*Y_W-1:0]       ch_y_i,
  input  logic [N_CH*C_W-1:0]       ch_colour_i,
  input  logic [N_CH-1:0]           ch_plot_i,
  output logic [X_W-1:0]            x_out_o,
  output logic [Y_W-1:0]            y_out_o,
  output logic [C_W-1:0]            colour_out_o,
  output logic                      plot_out_o,
  output logic [$clog2(N_CH)-1:0]   cur_ch_o,
  output logic                      busy_o,
  output logic                      round_done_o,
  output logic                      timeout_err_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam state_e RESET_STATE = (WAIT_FRAME != 0) ? ST_SYNC : ST_SCAN;

  state_e          state_q, state_d;
  logic [CH_W:0]   p_q, p_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            pending_q, pending_d;
  logic            terr_q, terr_d;
  logic [CH_W-1:0] pick_idx;
  logic            pick_found;

  draw_pick #(
    .N_CH  (N_CH),
    .IDX_W (CH_W)
  ) u_pick (
    .mask_i  (ch_en_i),
    .p_i     (p_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Register all scheduler state; reset parks in SYNC or SCAN depending on frame locking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= RESET_STATE;
      p_q       <= '0;
      cur_ch_q  <= '0;
      wd_q      <= '0;
      pending_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      cur_ch_q  <= cur_ch_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
      terr_q    <= terr_d;
    end
  end

  // Next-state logic: pick a channel, hold the grant until done or watchdog, then wait for a frame.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cur_ch_d  = cur_ch_q;
    wd_d      = wd_q;
    pending_d = pending_q | frame_tick_i;
    terr_d    = terr_q;
    case (state_q)
      ST_SCAN: begin
        if (pick_found) begin
          cur_ch_d = pick_idx;
          p_d      = {1'b0, pick_idx} + 1'b1;
          wd_d     = '0;
          state_d  = ST_RUN;
        end else begin
          p_d     = '0;
          state_d = (WAIT_FRAME != 0) ? ST_SYNC : ST_SCAN;
        end
      end
      ST_RUN: begin
        if (done_i[cur_ch_q]) begin
          state_d = ST_SCAN;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d = ST_SCAN;
          terr_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_SYNC: begin
        if (pending_q) begin
          state_d   = ST_SCAN;
          pending_d = frame_tick_i;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Grant, status and pixel mux outputs; strobes are held low while reset is asserted.
  always_comb begin
    go_o = '0;
    if (resetn && (state_q == ST_RUN)) go_o[cur_ch_q] = 1'b1;
    busy_o        = resetn && (state_q == ST_RUN);
    round_done_o  = resetn && (state_q == ST_SCAN) && !pick_found;
    plot_out_o    = ch_plot_i[cur_ch_q] && busy_o;
    x_out_o       = ch_x_i[int'(cur_ch_q)*X_W +: X_W];
    y_out_o       = ch_y_i[int'(cur_ch_q)*Y_W +: Y_W];
    colour_out_o  = ch_colour_i[int'(cur_ch_q)*C_W +: C_W];
    cur_ch_o      = cur_ch_q;
    timeout_err_o = terr_q;
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: free-running rounds with watchdog on
// instance A, frame-locked rounds on instance B.
module tb_draw_scheduler;

  logic clk;

  // Shared pixel buses (4 channels).
  logic [31:0] chX;
  logic [27:0] chY;
  logic [11:0] chC;
  logic [3:0]  chPlot;

  // Instance A: WAIT_FRAME=0, TIMEOUT=16.
  logic       rstnA, tickA;
  logic [3:0] enA, doneA, goA;
  logic [7:0] xA;
  logic [6:0] yA;
  logic [2:0] cA;
  logic       plotA, busyA, rdA, toA;
  logic [1:0] curA;

  // Instance B: WAIT_FRAME=1, TIMEOUT=16.
  logic       rstnB, tickB;
  logic [3:0] enB, doneB, goB;
  logic [7:0] xB;
  logic [6:0] yB;
  logic [2:0] cB;
  logic       plotB, busyB, rdB, toB;
  logic [1:0] curB;

  int testsRun = 0;
  int failCount = 0;

  draw_scheduler #(.N_CH(4), .TIMEOUT(16), .WAIT_FRAME(0)) dutA (
    .clk(clk), .resetn(rstnA), .ch_en_i(enA), .frame_tick_i(tickA),
    .go_o(goA), .done_i(doneA), .ch_x_i(chX), .ch_y_i(chY),
    .ch_colour_i(chC), .ch_plot_i(chPlot), .x_out_o(xA), .y_out_o(yA),
    .colour_out_o(cA), .plot_out_o(plotA), .cur_ch_o(curA), .busy_o(busyA),
    .round_done_o(rdA), .timeout_err_o(toA)
  );

  draw_scheduler #(.N_CH(4), .TIMEOUT(16), .WAIT_FRAME(1)) dutB (
    .clk(clk), .resetn(rstnB), .ch_en_i(enB), .frame_tick_i(tickB),
    .go_o(goB), .done_i(doneB), .ch_x_i(chX), .ch_y_i(chY),
    .ch_colour_i(chC), .ch_plot_i(chPlot), .x_out_o(xB), .y_out_o(yB),
    .colour_out_o(cB), .plot_out_o(plotB), .cur_ch_o(curB), .busy_o(busyB),
    .round_done_o(rdB), .timeout_err_o(toB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Expects channel ch granted now; raises other channels' done while waiting, then its own.
  task automatic serveA(input int ch);
    logic [3:0] m;
    m = 4'b0001 << ch;
    checkOutput("grantA", {28'd0, goA}, {28'd0, m});
    checkOutput("curA", {30'd0, curA}, ch);
    checkOutput("busyA", {31'd0, busyA}, 32'd1);
    doneA = ~m;
    applyStimulus(4);
    checkOutput("holdA", {28'd0, goA}, {28'd0, m});
    doneA = m;
    applyStimulus(1);
    doneA = 4'b0000;
    checkOutput("releaseA", {28'd0, goA}, 32'd0);
    checkOutput("idleBusyA", {31'd0, busyA}, 32'd0);
  endtask

  initial begin
    int cnt;
    int goCnt;
    int rdCnt;
    rstnA = 1'b0; rstnB = 1'b0; tickA = 1'b0; tickB = 1'b0;
    enA = 4'b1011; enB = 4'b0001; doneA = '0; doneB = '0;
    chX = '0; chY = '0; chC = '0; chPlot = '0;

    // Reset state
    applyStimulus(2);
    checkOutput("rstGoA", {28'd0, goA}, 32'd0);
    checkOutput("rstBusyA", {31'd0, busyA}, 32'd0);
    checkOutput("rstRdA", {31'd0, rdA}, 32'd0);
    checkOutput("rstToA", {31'd0, toA}, 32'd0);
    checkOutput("rstGoB", {28'd0, goB}, 32'd0);

    // Free-running round with mask 1011: grants 0,1,3 then round_done, then repeat
    rstnA = 1'b1;
    applyStimulus(1);
    serveA(0);
    applyStimulus(1);
    serveA(1);
    applyStimulus(1);
    serveA(3);
    checkOutput("roundDoneA", {31'd0, rdA}, 32'd1);
    applyStimulus(1);
    checkOutput("roundDoneOnceA", {31'd0, rdA}, 32'd0);
    applyStimulus(1);
    serveA(0);

    // Watchdog: mask 0111, ch0 done exactly on the last allowed cycle, ch1 never done
    rstnA = 1'b0; enA = 4'b0111;
    chX = {8'h00, 8'h50, 8'h00, 8'h11};
    chY = {7'h00, 7'h3C, 7'h00, 7'h22};
    chC = {3'd0, 3'b101, 3'd0, 3'd3};
    chPlot = 4'b0100;
    applyStimulus(1);
    checkOutput("midRstGoA", {28'd0, goA}, 32'd0);
    rstnA = 1'b1;
    applyStimulus(1);
    checkOutput("wdGrant0", {28'd0, goA}, 32'h1);
    checkOutput("otherPlotMasked", {31'd0, plotA}, 32'd0);
    checkOutput("muxX0", {24'd0, xA}, 32'h11);
    applyStimulus(15);
    checkOutput("wdLastCycle", {28'd0, goA}, 32'h1);
    doneA = 4'b0001;
    applyStimulus(1);
    doneA = 4'b0000;
    checkOutput("doneBeatsTimeout", {31'd0, toA}, 32'd0);
    applyStimulus(1);
    checkOutput("wdGrant1", {28'd0, goA}, 32'h2);
    cnt = 0;
    while (goA[1] && cnt < 40) begin
      cnt++;
      applyStimulus(1);
    end
    checkOutput("wdRunCycles", cnt, 32'd16);
    checkOutput("wdDropGo", {28'd0, goA}, 32'd0);
    checkOutput("wdErrSet", {31'd0, toA}, 32'd1);
    applyStimulus(1);
    checkOutput("afterWdGrant2", {28'd0, goA}, 32'h4);
    checkOutput("plotPass", {31'd0, plotA}, 32'd1);
    checkOutput("muxX2", {24'd0, xA}, 32'h50);
    checkOutput("muxY2", {25'd0, yA}, 32'h3C);
    checkOutput("muxC2", {29'd0, cA}, 32'h5);

    // Disabling the granted channel does not abort its grant
    enA = 4'b0011;
    applyStimulus(3);
    checkOutput("enClearKeepsGrant", {28'd0, goA}, 32'h4);
    doneA = 4'b0100;
    applyStimulus(1);
    doneA = 4'b0000;
    checkOutput("errSticky", {31'd0, toA}, 32'd1);
    checkOutput("roundDoneAfter2", {31'd0, rdA}, 32'd1);
    applyStimulus(2);
    checkOutput("nextRoundCh0", {28'd0, goA}, 32'h1);
    doneA = 4'b0001;
    applyStimulus(1);
    doneA = 4'b0000;
    applyStimulus(1);
    checkOutput("preRstGrant1", {28'd0, goA}, 32'h2);

    // Reset for one cycle in the middle of ch1's grant
    rstnA = 1'b0;
    applyStimulus(1);
    checkOutput("rstDropGo", {28'd0, goA}, 32'd0);
    checkOutput("rstClrErr", {31'd0, toA}, 32'd0);
    checkOutput("rstCurCh", {30'd0, curA}, 32'd0);
    rstnA = 1'b1;
    applyStimulus(1);
    checkOutput("postRstGrant0", {28'd0, goA}, 32'h1);

    // Empty mask in free-running mode pulses round_done every cycle
    enA = 4'b0000;
    doneA = 4'b0001;
    applyStimulus(1);
    doneA = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput("emptyRoundDone", {31'd0, rdA}, 32'd1);
      applyStimulus(1);
    end

    // Frame-locked instance: idle in SYNC until a tick
    rstnB = 1'b1;
    applyStimulus(4);
    checkOutput("syncIdleGoB", {28'd0, goB}, 32'd0);
    checkOutput("syncIdleBusyB", {31'd0, busyB}, 32'd0);
    tickB = 1'b1;
    applyStimulus(1);
    tickB = 1'b0;
    cnt = 0;
    while (goB != 4'b0001 && cnt < 10) begin
      cnt++;
      applyStimulus(1);
    end
    checkOutput("tickGrantB", {28'd0, goB}, 32'h1);

    // Two ticks while ch0 is busy collapse into exactly one extra round
    tickB = 1'b1;
    applyStimulus(1);
    tickB = 1'b0;
    applyStimulus(1);
    tickB = 1'b1;
    applyStimulus(1);
    tickB = 1'b0;
    checkOutput("busyThroughTicksB", {28'd0, goB}, 32'h1);
    goCnt = 0;
    rdCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (goB[0]) goCnt++;
      if (rdB) rdCnt++;
      doneB = goB;
      applyStimulus(1);
    end
    doneB = 4'b0000;
    checkOutput("extraRoundGrants", goCnt, 32'd2);
    checkOutput("extraRoundDones", rdCnt, 32'd2);
    checkOutput("finalIdleBusyB", {31'd0, busyB}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of drawer channels (2..8).
REQ-002 Parameter X_W, default 8, pixel x width.
REQ-003 Parameter Y_W, default 7, pixel y width.
REQ-004 Parameter C_W, default 3, colour width.
REQ-005 Parameter TIMEOUT, default 4096, max cycles a channel may hold the grant; 0 disables the watchdog.
REQ-006 Parameter WAIT_FRAME, default 1, 1 = one round per frame_tick, 0 = free-running rounds.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 resetn  in  1  reset, synchronous, active-low.
REQ-009 ch_en  in  N_CH  per-channel enable mask.
REQ-010 frame_tick  in  1  single-cycle frame strobe.
REQ-011 go  out  N_CH  one-hot grant to drawers.
REQ-012 done  in  N_CH  drawer completion, one bit per channel.
REQ-013 ch_x / ch_y / ch_colour  in  N_CH*X_W / N_CH*Y_W / N_CH*C_W  packed drawer pixel buses, channel i at slice i.
REQ-014 ch_plot  in  N_CH  drawer write strobes.
REQ-015 x_out / y_out / colour_out / plot_out  out  X_W / Y_W / C_W / 1  muxed pixel port to vga_adapter.
REQ-016 cur_ch  out  clog2(N_CH)  index of the channel last or currently granted.
REQ-017 busy  out  1  high while in RUN.
REQ-018 round_done  out  1  one-cycle pulse at end of each round.
REQ-019 timeout_err  out  1  sticky watchdog flag.

Function
REQ-020 FSM states SCAN, RUN, SYNC; registered state, one transition per cycle max.
REQ-021 SCAN: pointer p selects the lowest index i >= p with ch_en[i]=1; if found, cur_ch<=i, p<=i+1, next state RUN.
REQ-022 SCAN with no eligible index: round_done=1 that cycle, p<=0, next state SYNC if WAIT_FRAME=1 else SCAN.
REQ-023 A round never wraps: each enabled channel is granted at most once per round, in ascending index order.
REQ-024 RUN: go[cur_ch]=1, all other go bits 0; go is 0 in SCAN and SYNC.
REQ-025 RUN exits to SCAN on the cycle after done[cur_ch]=1 is sampled; done bits of non-granted channels are ignored.
REQ-026 Watchdog counter clears on RUN entry, increments each RUN cycle; when it reaches TIMEOUT-1 with no done, the grant is aborted (next state SCAN) and timeout_err<=1.
REQ-027 done and timeout in the same cycle: treated as done, timeout_err unchanged.
REQ-028 Clearing ch_en[cur_ch] during RUN does not abort the current grant; it only affects later SCANs.
REQ-029 frame_tick is latched into a pending flag in any state; SYNC exits to SCAN when pending=1 and clears it in the same cycle; multiple ticks before consumption collapse to one.
REQ-030 x_out/y_out/colour_out are a combinational mux of channel cur_ch; plot_out = ch_plot[cur_ch] AND (state==RUN).
REQ-031 busy = (state==RUN); round_done high only in the REQ-022 cycle.
REQ-032 With ch_en all zero and WAIT_FRAME=0, round_done asserts every cycle.

Reset
REQ-033 On resetn=0 at a clock edge: state<=SYNC if WAIT_FRAME=1 else SCAN; p, cur_ch, watchdog, pending, timeout_err <=0.
REQ-034 During and immediately after reset, go=0, plot_out=0, busy=0, round_done=0; reset mid-RUN drops the grant on the next edge.

Structure
REQ-035 Package draw_sched_pkg holds the state encoding and default width constants (X_W=8, Y_W=7, C_W=3).
REQ-036 One sub-module draw_pick: combinational lowest-set-bit-at-or-above-p search, outputs index and found flag.

Verification
REQ-037 N_CH=4, ch_en=4'b1011, WAIT_FRAME=0, each drawer done 5 cycles after go -> grants 0,1,3 in order, round_done pulses after ch3, repeats.
REQ-038 WAIT_FRAME=1, ch_en=4'b0001, ticks 2 cycles apart while ch0 busy -> exactly one extra round, then SYNC idle.
REQ-039 TIMEOUT=16, ch1 never asserts done -> go[1] drops after 16 RUN cycles, timeout_err=1 and stays 1, ch2 granted next.
REQ-040 ch2 plots (x=8'h50,y=7'h3C,colour=3'b101) while ch0 granted -> plot_out=0; same data when ch2 granted -> passes through unchanged.
REQ-041 resetn=0 for one cycle mid-RUN of ch1 -> next cycle go=0, timeout_err=0, cur_ch=0, first grant after reset is ch0.
